// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD write-cycle controller.
//   - lcd_state_t : controller phases (INIT_PWR/INIT_CMD only reachable when
//                   LCD_INIT_EN is defined)
//   - field bit positions inside the 32-bit LCD register word
//   - lcd_cmd_t   : one issued HD44780 write (backlight/power, RS, DATA)
//   - INIT_CMDS   : power-on command table (function set, display on,
//                   clear, entry mode)
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT_PWR,
    INIT_CMD,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam int LCD_ON_BIT  = 31;
  localparam int LCD_CLR_BIT = 30;
  localparam int LCD_RS_BIT  = 9;

  localparam int INIT_CMD_NUM = 4;
  localparam logic [7:0] INIT_CMDS [INIT_CMD_NUM] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  typedef struct packed {
    logic       on;
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input lcd_cmd_t cmd);
    return !cmd.rs && (cmd.data[7:2] == 6'd0) && (cmd.data[1:0] != 2'd0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every timed phase.
//   clk_i  : system clock
//   rst_i  : synchronous reset, active-high; counter takes RST_VAL
//   load_i : load val_i this cycle (phase entry)
//   val_i  : phase length minus one
//   done_o : counter has reached zero (last cycle of the phase)
module lcd_timer #(
  parameter int             CW      = 8,
  parameter logic [CW-1:0]  RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= RST_VAL;
    end else if (load_i) begin
      cnt <= val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done_o = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns stores to the LCD register into timed HD44780 8-bit
// write cycles (SETUP -> EN PULSE -> HOLD -> execution WAIT), with a
// one-entry pending buffer and a sticky overflow flag.
//   clk_i      : system clock
//   rst_i      : synchronous reset, active-high
//   lcd_wr_i   : one-cycle store strobe
//   lcd_word_i : [31]=ON, [30]=CLR_OVF, [9]=RS, [7:0]=DATA
//   lcd_data_o, lcd_rs_o, lcd_rw_o (tied 0), lcd_en_o, lcd_on_o : panel pins
//   busy_o     : a cycle is in flight or a word is pending
//   ovf_o      : sticky, a store was dropped; cleared by a CLR_OVF store
// Optional feature: define LCD_INIT_EN to run the power-up wait and the
// four-command init sequence out of reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_PULSE_CYC = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lcd_wr_i,
  input  logic [31:0] lcd_word_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_SETUP_CYC, T_PULSE_CYC),
                                         max_int(T_HOLD_CYC, T_EXEC_CYC)),
                                 max_int(T_LONG_CYC, T_PWRUP_CYC));
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(T_LONG_CYC - 1);

`ifdef LCD_INIT_EN
  localparam lcd_state_t    RST_STATE = INIT_PWR;
  localparam logic [CW-1:0] TMR_RST   = CW'(T_PWRUP_CYC - 1);
`else
  localparam lcd_state_t    RST_STATE = IDLE;
  localparam logic [CW-1:0] TMR_RST   = '0;
`endif

  lcd_state_t    state, state_nx;
  lcd_cmd_t      cur, issue_cmd, pend, word_cmd;
  logic          pend_valid, pend_valid_nx, pend_load;
  logic          ovf, ovf_nx;
  logic          en_q, busy_q;
  logic          issue, bypass;
  logic          accept, clr_ovf;
  logic          tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;
  logic          unused_bits;

`ifdef LCD_INIT_EN
  logic [2:0] init_idx, init_idx_nx;
  logic       init_left;
  assign init_left = (init_idx != 3'(INIT_CMD_NUM));
`endif

  assign accept        = lcd_wr_i && !lcd_word_i[LCD_CLR_BIT];
  assign clr_ovf       = lcd_wr_i &&  lcd_word_i[LCD_CLR_BIT];
  assign word_cmd.on   = lcd_word_i[LCD_ON_BIT];
  assign word_cmd.rs   = lcd_word_i[LCD_RS_BIT];
  assign word_cmd.data = lcd_word_i[7:0];
  assign unused_bits   = ^{lcd_word_i[29:10], lcd_word_i[8]};

  lcd_timer #(
    .CW      (CW),
    .RST_VAL (TMR_RST)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    pend_valid_nx = pend_valid;
    pend_load     = 1'b0;
    ovf_nx        = ovf;
    issue         = 1'b0;
    issue_cmd     = pend;
    bypass        = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = SETUP_LD;
`ifdef LCD_INIT_EN
    init_idx_nx   = init_idx;
`endif

    unique case (state)
      IDLE: begin
        if (pend_valid) begin
          issue         = 1'b1;
          pend_valid_nx = 1'b0;
        end else if (accept) begin
          issue     = 1'b1;
          issue_cmd = word_cmd;
          bypass    = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_nx = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          state_nx = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_nx = WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(cur) ? LONG_LD : EXEC_LD;
        end
      end
      WAIT: begin
        // Chain straight into the next cycle so back-to-back words never
        // see an IDLE cycle in between.
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          if (init_left) state_nx = INIT_CMD;
          else
`endif
          if (pend_valid) begin
            issue         = 1'b1;
            pend_valid_nx = 1'b0;
          end else if (accept) begin
            issue     = 1'b1;
            issue_cmd = word_cmd;
            bypass    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
`ifdef LCD_INIT_EN
      INIT_PWR: begin
        if (tmr_done) state_nx = INIT_CMD;
      end
      INIT_CMD: begin
        issue          = 1'b1;
        issue_cmd.on   = 1'b1;
        issue_cmd.rs   = 1'b0;
        issue_cmd.data = INIT_CMDS[init_idx[1:0]];
        init_idx_nx    = init_idx + 3'd1;
      end
`endif
      default: state_nx = IDLE;
    endcase

    if (issue) begin
      state_nx = SETUP;
      tmr_load = 1'b1;
      tmr_val  = SETUP_LD;
    end

    // A slot freed by an issue this same cycle is refilled without overflow.
    if (accept && !bypass) begin
      if (pend_valid_nx) begin
        ovf_nx = 1'b1;
      end else begin
        pend_valid_nx = 1'b1;
        pend_load     = 1'b1;
      end
    end

    if (clr_ovf) ovf_nx = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RST_STATE;
      pend_valid <= 1'b0;
      ovf        <= 1'b0;
      cur        <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_valid <= pend_valid_nx;
      ovf        <= ovf_nx;
      en_q       <= (state_nx == PULSE);
      busy_q     <= (state_nx != IDLE) || pend_valid_nx;
      if (issue) cur <= issue_cmd;
    end
  end

  // NOTE: the pending payload is qualified by pend_valid, so it carries no
  // reset; only the valid bit must be cleared.
  always_ff @(posedge clk_i) begin
    if (pend_load) pend <= word_cmd;
  end

`ifdef LCD_INIT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) init_idx <= 3'd0;
    else       init_idx <= init_idx_nx;
  end
`endif

  assign lcd_data_o = cur.data;
  assign lcd_rs_o   = cur.rs;
  assign lcd_on_o   = cur.on;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign busy_o     = busy_q;
  assign ovf_o      = ovf;

endmodule
